// File: rtl/pciei_sram_fifo_ctrl_pkg.sv
// rtl/pciei_sram_fifo_ctrl_pkg.sv - shared constants and push/pop qualifiers for pciei FIFOs
package pciei_sram_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    FIFO_ERR_NONE      = 2'd0,
    FIFO_ERR_OVERFLOW  = 2'd1,
    FIFO_ERR_UNDERFLOW = 2'd2
  } fifo_err_e;

  localparam logic [2:0] OUT_STAGE_DEPTH = 3'd2;

  function automatic logic push_qual(input logic wr_en, input logic full);
    return wr_en & ~full;
  endfunction

  function automatic logic pop_qual(input logic rd_en, input logic empty);
    return rd_en & ~empty;
  endfunction

endpackage

// File: rtl/pciei_fifo_out_stage.sv
// rtl/pciei_fifo_out_stage.sv - two-entry head/skid output register for FWFT FIFOs
module pciei_fifo_out_stage
  import pciei_sram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 88
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            out_cnt
);

  logic [DATA_WIDTH-1:0] head_q, head_d, skid_q, skid_d;
  logic [1:0]            cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    cnt_d  = cnt_q;
    if (pop && cnt_q == 2'd2) head_d = skid_q;
    // a return lands in head only when head is free (or being vacated with no skid behind it)
    if (load) begin
      if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) head_d = load_data;
      else skid_d = load_data;
    end
    case ({load, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head    = head_q;
  assign out_cnt = cnt_q;

endmodule

// File: rtl/pciei_sram_fifo_ctrl.sv
// rtl/pciei_sram_fifo_ctrl.sv - FWFT FIFO controller using an external two-port SRAM as storage
// Pointers, occupancy counters and SRAM strobes live here; the head/skid stage is a sub-module.
module pciei_sram_fifo_ctrl
  import pciei_sram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 88,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  sram_wr_cen,
  output logic [ADDR_WIDTH-1:0] sram_wr_a,
  output logic [DATA_WIDTH-1:0] sram_wr_d,
  output logic                  sram_rd_cen,
  output logic [ADDR_WIDTH-1:0] sram_rd_a,
  input  logic [DATA_WIDTH-1:0] sram_rd_q
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d, count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic [1:0]            out_cnt;
  logic [2:0]            stage_occ;
  logic                  push, pop, issue;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (out_cnt == 2'd0);
  // the write strobe must read idle while reset is held, whatever wr_en does
  assign push  = push_qual(wr_en, full) & rst_n;
  assign pop   = pop_qual(rd_en, empty);

  // only prefetch when the output stage will still have room once the read returns
  assign stage_occ = {1'b0, out_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (mem_cnt_q != '0) && (stage_occ < OUT_STAGE_DEPTH);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_cnt_d   = mem_cnt_q;
    count_d     = count_q;
    inflight_d  = issue;
    overflow_d  = wr_en & full;
    underflow_d = rd_en & empty;
    if (push)  wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (issue) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, issue})
      2'b10:   mem_cnt_d = mem_cnt_q + CNT_ONE;
      2'b01:   mem_cnt_d = mem_cnt_q - CNT_ONE;
      default: mem_cnt_d = mem_cnt_q;
    endcase
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  pciei_fifo_out_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (inflight_q),
    .load_data(sram_rd_q),
    .pop      (pop),
    .head     (rd_data),
    .out_cnt  (out_cnt)
  );

  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign sram_wr_cen = ~push;
  assign sram_wr_a   = wr_ptr_q;
  assign sram_wr_d   = push ? wr_data : '0;
  assign sram_rd_cen = ~issue;
  assign sram_rd_a   = rd_ptr_q;

endmodule

// File: tb/tb_pciei_sram_fifo_ctrl.sv
// tb/tb_pciei_sram_fifo_ctrl.sv - self-checking bench with SRAM model and data scoreboard
module tb_pciei_sram_fifo_ctrl;

  localparam int DW    = 88;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n, wr_en, rd_en;
  logic [DW-1:0] wr_data, rd_data, sram_wr_d, sram_rd_q;
  logic          full, empty, overflow, underflow, sram_wr_cen, sram_rd_cen;
  logic [AW:0]   count;
  logic [AW-1:0] sram_wr_a, sram_rd_a;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pciei_sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow),
    .sram_wr_cen(sram_wr_cen), .sram_wr_a(sram_wr_a), .sram_wr_d(sram_wr_d),
    .sram_rd_cen(sram_rd_cen), .sram_rd_a(sram_rd_a), .sram_rd_q(sram_rd_q)
  );

  // two-port SRAM with registered read
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!sram_wr_cen) mem[sram_wr_a] <= sram_wr_d;
    if (!sram_rd_cen) sram_rd_q <= mem[sram_rd_a];
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (empty && n < 16) begin
      tick();
      n++;
    end
    chkn(tag, int'(empty), 0);
  endtask

  // scoreboard and reference model, sampled mid-cycle
  logic [DW-1:0] sb [$];
  int            mcount;
  logic          exp_ovf, exp_unf, mpush;
  logic [AW-1:0] exp_wa, exp_ra;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      mcount  = 0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
      exp_wa  = '0;
      exp_ra  = '0;
    end else begin
      chkn("mon_count", int'(count), mcount);
      chkn("mon_full", int'(full), int'(mcount == DEPTH));
      chkn("mon_overflow", int'(overflow), int'(exp_ovf));
      chkn("mon_underflow", int'(underflow), int'(exp_unf));
      mpush = wr_en && (mcount != DEPTH);
      chkn("mon_wr_cen", int'(sram_wr_cen), int'(!mpush));
      if (mpush) begin
        chkn("mon_wr_addr", int'(sram_wr_a), int'(exp_wa));
        chk("mon_wr_data", sram_wr_d, wr_data);
        exp_wa++;
      end
      if (!sram_rd_cen) begin
        chkn("mon_rd_addr", int'(sram_rd_a), int'(exp_ra));
        exp_ra++;
      end
      if (!sram_wr_cen && !sram_rd_cen)
        chkn("mon_no_rw_collide", int'(sram_wr_a != sram_rd_a), 1);
      if (rd_en && !empty) begin
        chkn("mon_sb_has_entry", int'(sb.size() > 0), 1);
        if (sb.size() > 0) chk("mon_pop_data", rd_data, sb.pop_front());
        mcount--;
      end
      if (mpush) begin
        sb.push_back(wr_data);
        mcount++;
      end
      exp_ovf = wr_en && !mpush;
      exp_unf = rd_en && empty;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    tick(); tick();
    chkn("rst_empty", int'(empty), 1);
    chkn("rst_full", int'(full), 0);
    chkn("rst_count", int'(count), 0);
    chkn("rst_wr_cen", int'(sram_wr_cen), 1);
    chkn("rst_rd_cen", int'(sram_rd_cen), 1);
    chkn("rst_flags", int'({overflow, underflow}), 0);
    chkn("rst_addrs", int'({sram_wr_a, sram_rd_a}), 0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_wr_d", sram_wr_d, '0);
    rst_n = 1'b1;
    tick();

    // 1: first-word latency
    wr_en = 1'b1; wr_data = 88'hA5;
    #1;
    chkn("t1_wr_cen", int'(sram_wr_cen), 0);
    chkn("t1_wr_a", int'(sram_wr_a), 0);
    chk("t1_wr_d", sram_wr_d, 88'hA5);
    tick();
    wr_en = 1'b0;
    #1;
    chkn("t1_rd_cen", int'(sram_rd_cen), 0);
    chkn("t1_rd_a", int'(sram_rd_a), 0);
    chkn("t1_empty_t1", int'(empty), 1);
    tick();
    chkn("t1_empty_t2", int'(empty), 1);
    tick();
    chkn("t1_empty_after_t2", int'(empty), 0);
    chk("t1_rd_data", rd_data, 88'hA5);
    chkn("t1_count", int'(count), 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chkn("t1_drained", int'(empty), 1);

    // 2: fill to full, overflow, simultaneous push/pop when full, drain
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      tick();
    end
    wr_en = 1'b0;
    chkn("t2_full", int'(full), 1);
    chkn("t2_count_full", int'(count), DEPTH);
    wr_en = 1'b1; wr_data = 88'hDEAD;
    #1;
    chkn("t2_ovf_wr_cen", int'(sram_wr_cen), 1);
    tick();
    chkn("t2_overflow", int'(overflow), 1);
    rd_en = 1'b1; wr_data = 88'hBEEF;
    #1;
    chkn("t2_full_rw_wr_cen", int'(sram_wr_cen), 1);
    tick();
    wr_en = 1'b0;
    chkn("t2_full_rw_count", int'(count), DEPTH - 1);
    for (int i = 1; i < DEPTH; i++) begin
      chkn("t2_pop_ready", int'(empty), 0);
      chk("t2_pop_value", rd_data, DW'(i));
      tick();
    end
    rd_en = 1'b0;
    chkn("t2_empty", int'(empty), 1);
    chkn("t2_sb_drained", sb.size(), 0);

    // 3: streaming at half-full across pointer wraps
    for (int i = 0; i < DEPTH / 2; i++) begin
      wr_en = 1'b1; wr_data = DW'(32'h1000 + i);
      tick();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      wr_data = DW'({$urandom(), $urandom(), $urandom()});
      chkn("t3_count", int'(count), DEPTH / 2);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < DEPTH / 2; i++) tick();
    rd_en = 1'b0;
    chkn("t3_empty", int'(empty), 1);
    chkn("t3_count_end", int'(count), 0);

    // 4: underflow, alone and alongside a push
    rd_en = 1'b1;
    #1;
    chkn("t4_rd_cen", int'(sram_rd_cen), 1);
    tick();
    rd_en = 1'b0;
    chkn("t4_underflow", int'(underflow), 1);
    chkn("t4_count", int'(count), 0);
    tick();
    chkn("t4_underflow_once", int'(underflow), 0);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 88'h5A;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chkn("t4_wr_rd_underflow", int'(underflow), 1);
    chkn("t4_wr_rd_count", int'(count), 1);
    wait_ready("t4_ready");
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;

    // 5: stalled pop caps prefetch at two, then a back-to-back burst
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      tick();
    end
    wr_en = 1'b0;
    repeat (4) tick();
    chkn("t5_prefetch_stall", int'(sram_rd_cen), 1);
    chkn("t5_count", int'(count), 3);
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chkn("t5_burst_ready", int'(empty), 0);
      chk("t5_burst_data", rd_data, DW'(i));
      tick();
    end
    rd_en = 1'b0;
    chkn("t5_empty", int'(empty), 1);

    // 6: asynchronous reset with a read in flight
    wr_en = 1'b1; wr_data = 88'h11;
    tick();
    wr_en = 1'b0;
    tick();
    wr_en = 1'b1; wr_data = 88'h77;
    rst_n = 1'b0;
    #1;
    chkn("t6_empty", int'(empty), 1);
    chkn("t6_count", int'(count), 0);
    chkn("t6_full", int'(full), 0);
    chkn("t6_wr_cen", int'(sram_wr_cen), 1);
    chkn("t6_rd_cen", int'(sram_rd_cen), 1);
    chkn("t6_addrs", int'({sram_wr_a, sram_rd_a}), 0);
    chk("t6_rd_data", rd_data, '0);
    chk("t6_wr_d", sram_wr_d, '0);
    tick(); tick();
    wr_en = 1'b0;
    rst_n = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 88'h3C;
    tick();
    wr_en = 1'b0;
    wait_ready("t6_ready");
    chk("t6_first_entry", rd_data, 88'h3C);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chkn("t6_empty_end", int'(empty), 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
